// File: rtl/draw_arbiter_pkg.sv
// Shared definitions for the VGA draw-port arbiter: FSM encodings, pixel
// coordinate width and the colour used when a requester is erasing.
package draw_arbiter_pkg;

  localparam int COORD_W = 10;
  localparam int BLACK   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/draw_arb_pick.sv
// Combinational winner select: first requesting index at or after ptr,
// searching cyclically. With ptr held at 0 this is plain fixed priority.
module draw_arb_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic found;
  int   idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Multiplexes NREQ pixel-drawing requesters onto one VGA adapter port.
// Define DRAW_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           done,
  input  logic [NREQ-1:0]           plot_in,
  input  logic [NREQ*COORD_W-1:0]   x_in,
  input  logic [NREQ*COORD_W-1:0]   y_in,
  input  logic [NREQ*CW-1:0]        colour_in,
  input  logic [NREQ-1:0]           erase_in,
  output logic [NREQ-1:0]           gnt,
  output logic [COORD_W-1:0]        x,
  output logic [COORD_W-1:0]        y,
  output logic [CW-1:0]             colour,
  output logic                      writeEn,
  output logic                      busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state, state_d;
  logic [NREQ-1:0]     gnt_d, win;
  logic [COORD_W-1:0]  x_d, y_d;
  logic [CW-1:0]       colour_d;
  logic                we_d;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       ptr;
  logic                burst_end;

  // Index of the current owner; gnt is one-hot whenever it matters.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gidx = PW'(i);
  end

  assign burst_end = (state == ST_BURST) && (done[gidx] || !req[gidx]);
  assign busy      = (state != ST_IDLE);

`ifdef DRAW_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        ptr <= '0;
    else if (burst_end) ptr <= PW'((int'(gidx) + 1) % NREQ);
  end
`else
  assign ptr = '0;
`endif

  draw_arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    we_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = win;
          state_d = ST_GRANT;
        end else begin
          gnt_d = '0;
        end
      end
      ST_GRANT: state_d = ST_BURST;
      ST_BURST: begin
        // Only the owner's strobe matters; a plot alongside done is still taken.
        we_d = plot_in[gidx];
        if (plot_in[gidx]) begin
          x_d      = x_in[COORD_W*gidx +: COORD_W];
          y_d      = y_in[COORD_W*gidx +: COORD_W];
          colour_d = erase_in[gidx] ? CW'(BLACK) : colour_in[CW*gidx +: CW];
        end
        if (burst_end) begin
          state_d = ST_GAP;
          gnt_d   = '0;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      x       <= x_d;
      y       <= y_d;
      colour  <= colour_d;
      writeEn <= we_d;
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized plus directed bench for draw_arbiter against a behavioural model.
module tb_draw_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 3;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req = '0, done = '0, plot_in = '0, erase_in = '0;
  logic [NREQ*10-1:0] x_in = '0, y_in = '0;
  logic [NREQ*CW-1:0] colour_in = '0;
  logic [NREQ-1:0]   gnt;
  logic [9:0]        x, y;
  logic [CW-1:0]     colour;
  logic              writeEn, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_stage;   // 0 idle, 1 settle, 2 drawing, 3 gap
  int          m_owner;   // -1 when nobody owns the port
  int          m_ptr;
  int          m_x, m_y, m_col, m_we;

  always #5 clk = ~clk;

  draw_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .erase_in(erase_in),
    .gnt(gnt), .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_owner = -1; m_ptr = 0;
    m_x = 0; m_y = 0; m_col = 0; m_we = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int o;
    m_we = 0;
    case (m_stage)
      0: if (req != 0) begin m_owner = pick_winner(req, m_ptr); m_stage = 1; end
      1: m_stage = 2;
      2: begin
        o = m_owner;
        if (plot_in[o]) begin
          m_we  = 1;
          m_x   = int'(x_in[10*o +: 10]);
          m_y   = int'(y_in[10*o +: 10]);
          m_col = erase_in[o] ? 0 : int'(colour_in[CW*o +: CW]);
        end
        if (done[o] || !req[o]) begin
          m_stage = 3;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
          m_ptr = (o + 1) % NREQ;
`endif
          m_owner = -1;
        end
      end
      default: m_stage = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ".we"}, 32'(writeEn), 32'(m_we));
    chk({tag, ".busy"}, 32'(busy), (m_stage != 0) ? 32'd1 : 32'd0);
    chk({tag, ".x"}, 32'(x), 32'(m_x));
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".col"}, 32'(colour), 32'(m_col));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic clear_inputs();
    req = '0; done = '0; plot_in = '0; erase_in = '0;
    x_in = '0; y_in = '0; colour_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    resetn = 1'b1;

    // Basic grant and first pixel
    req = 4'b0110;
    step("d34a");
    chk("d34_gnt", 32'(gnt), 32'h2);
    step("d34b");
    plot_in = 4'b0010; x_in[19:10] = 10'd5; y_in[19:10] = 10'd7; colour_in[5:3] = 3'd3;
    step("d34c");
    chk("d34_x", 32'(x), 32'd5);
    chk("d34_y", 32'(y), 32'd7);
    chk("d34_we", 32'(writeEn), 32'd1);

    // Higher priority arrival must not preempt or leak pixels
    req = 4'b0011; plot_in = 4'b0011; x_in[9:0] = 10'd77;
    step("d35a");
    chk("d35_gnt", 32'(gnt), 32'h2);
    chk("d35_x", 32'(x), 32'd5);
    plot_in = 4'b0001; done = 4'b0001;
    step("d35b");
    chk("d35_nopre", 32'(gnt), 32'h2);
    plot_in = '0; done = 4'b0010;
    step("d35c");
    done = '0;
    step("d35d");
    step("d35e");
    chk("d35_next", 32'(gnt), 32'h1);
    req = '0;
    step("d35f");
    step("d35g");
    step("d35h");

    // Erase forces black
    req = 4'b0100;
    step("d36a");
    chk("d36_gnt", 32'(gnt), 32'h4);
    step("d36b");
    plot_in = 4'b0100; erase_in = 4'b0100; colour_in[8:6] = 3'b111;
    step("d36c");
    chk("d36_col", 32'(colour), 32'd0);
    chk("d36_we", 32'(writeEn), 32'd1);
    plot_in = '0; erase_in = '0; done = 4'b0100;
    step("d36d");
    done = '0; req = '0;
    step("d36e");

    // Plot together with done at the screen corner
    req = 4'b1000;
    step("d39a");
    step("d39b");
    plot_in = 4'b1000; done = 4'b1000; x_in[39:30] = 10'd159; y_in[39:30] = 10'd119;
    step("d39c");
    chk("d39_x", 32'(x), 32'd159);
    chk("d39_y", 32'(y), 32'd119);
    chk("d39_we", 32'(writeEn), 32'd1);
    clear_inputs();
    step("d39d");
    chk("d39_gap_we", 32'(writeEn), 32'd0);
    step("d39e");

`ifdef DRAW_ARB_ROUND_ROBIN_EN
    do_reset();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      step("rr_g");
      chk("rr_order", 32'(gnt), 32'd1 << (b % NREQ));
      step("rr_b");
      done = 4'(1 << (b % NREQ));
      step("rr_d");
      done = '0;
      step("rr_i");
    end
    clear_inputs();
`endif

    // Reset in the middle of a burst
    step("d38pre");
    req = 4'b0001;
    step("d38a");
    step("d38b");
    plot_in = 4'b0001; x_in[9:0] = 10'd33;
    step("d38c");
    chk("d38_we_pre", 32'(writeEn), 32'd1);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("d38_we", 32'(writeEn), 32'd0);
    chk("d38_gnt", 32'(gnt), 32'd0);
    chk("d38_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) step("d38post");
    clear_inputs();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        done[i]     = ($urandom_range(0, 7) == 0);
        plot_in[i]  = $urandom_range(0, 1) == 1;
        erase_in[i] = ($urandom_range(0, 3) == 0);
      end
      x_in      = {$urandom, $urandom};
      y_in      = {$urandom, $urandom};
      colour_in = 12'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
